// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: envelope state encoding and default datapath widths.
package synth_pkg;

    localparam int unsigned ENV_W    = 16;
    localparam int unsigned SAMPLE_W = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_e;

endpackage

// File: rtl/env_scaler.sv
// Scales a signed sample by an unsigned Q0.ENV_W_P level and registers the result.
module env_scaler
    import synth_pkg::*;
#(
    parameter int unsigned WIDTH_P = SAMPLE_W,
    parameter int unsigned ENV_W_P = ENV_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [WIDTH_P-1:0] din,
    input  logic [ENV_W_P-1:0]        level,
    output logic signed [WIDTH_P-1:0] dout,
    output logic                      dout_valid
);

    localparam int unsigned PROD_W = WIDTH_P + ENV_W_P + 1;

    logic signed [PROD_W-1:0] din_x;
    logic signed [PROD_W-1:0] level_x;
    logic signed [PROD_W-1:0] prod;
    logic                     unused_prod_bits;

    // Both operands widened to the full product width so the multiply is exact and signed.
    assign din_x   = PROD_W'(din);
    assign level_x = PROD_W'({1'b0, level});
    assign prod    = din_x * level_x;

    assign unused_prod_bits = ^{prod[PROD_W-1], prod[ENV_W_P-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= en;
            if (en) begin
                dout <= prod[ENV_W_P +: WIDTH_P];
            end
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gate-driven FSM with saturating level arithmetic feeding the scaler.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int unsigned WIDTH_P = SAMPLE_W,
    parameter int unsigned ENV_W_P = ENV_W
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic signed [WIDTH_P-1:0] sample_i,
    input  logic                      valid_i,
    input  logic                      gate_i,
    input  logic [ENV_W_P-1:0]        attack_step_i,
    input  logic [ENV_W_P-1:0]        decay_step_i,
    input  logic [ENV_W_P-1:0]        sustain_lvl_i,
    input  logic [ENV_W_P-1:0]        release_step_i,
    output logic signed [WIDTH_P-1:0] sample_o,
    output logic                      valid_o,
    output logic [ENV_W_P-1:0]        level_o,
    output logic [2:0]                state_o,
    output logic                      busy_o
);

    localparam logic [ENV_W_P:0] ENV_MAX_X = {1'b0, {ENV_W_P{1'b1}}};

    adsr_state_e          state_q, state_d;
    logic [ENV_W_P-1:0]   level_q, level_d;
    logic                 gate_q;
    logic                 rise, fall;
    logic [ENV_W_P:0]     atk_sum;
    logic [ENV_W_P:0]     dec_diff;

    assign rise = gate_i & ~gate_q;
    assign fall = ~gate_i & gate_q;

    assign atk_sum  = {1'b0, level_q} + {1'b0, attack_step_i};
    assign dec_diff = {1'b0, level_q} - {1'b0, decay_step_i};

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = ATTACK;
            end
            ATTACK: begin
                if (fall) begin
                    state_d = RELEASE;
                end else if (atk_sum >= ENV_MAX_X) begin
                    level_d = ENV_MAX_X[ENV_W_P-1:0];
                    state_d = DECAY;
                end else begin
                    level_d = atk_sum[ENV_W_P-1:0];
                end
            end
            DECAY: begin
                // A borrow out of the top bit means the step overshot zero, hence below sustain.
                if (fall) begin
                    state_d = RELEASE;
                end else if (dec_diff[ENV_W_P] || (dec_diff[ENV_W_P-1:0] <= sustain_lvl_i)) begin
                    level_d = sustain_lvl_i;
                    state_d = SUSTAIN;
                end else begin
                    level_d = dec_diff[ENV_W_P-1:0];
                end
            end
            SUSTAIN: begin
                if (fall) state_d = RELEASE;
                else      level_d = sustain_lvl_i;
            end
            RELEASE: begin
                if (rise) begin
                    state_d = ATTACK;
                end else if (level_q <= release_step_i) begin
                    level_d = '0;
                    state_d = IDLE;
                end else begin
                    level_d = level_q - release_step_i;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
        end else if (valid_i) begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate_i;
        end
    end

    env_scaler #(
        .WIDTH_P (WIDTH_P),
        .ENV_W_P (ENV_W_P)
    ) u_scaler (
        .clk        (clk_i),
        .rst        (reset_i),
        .en         (valid_i),
        .din        (sample_i),
        .level      (level_q),
        .dout       (sample_o),
        .dout_valid (valid_o)
    );

    assign level_o = level_q;
    assign state_o = state_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: reset, attack/decay/sustain/release, retrigger, valid gating.
module tb_adsr_envelope;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic               clk = 1'b0;
    logic               reset_i;
    logic signed [23:0] sample_i;
    logic               valid_i;
    logic               gate_i;
    logic [15:0]        attack_step_i;
    logic [15:0]        decay_step_i;
    logic [15:0]        sustain_lvl_i;
    logic [15:0]        release_step_i;
    logic signed [23:0] sample_o;
    logic               valid_o;
    logic [15:0]        level_o;
    logic [2:0]         state_o;
    logic               busy_o;

    int tests  = 0;
    int errors = 0;

    adsr_envelope #(
        .WIDTH_P (24),
        .ENV_W_P (16)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .sample_i       (sample_i),
        .valid_i        (valid_i),
        .gate_i         (gate_i),
        .attack_step_i  (attack_step_i),
        .decay_step_i   (decay_step_i),
        .sustain_lvl_i  (sustain_lvl_i),
        .release_step_i (release_step_i),
        .sample_o       (sample_o),
        .valid_o        (valid_o),
        .level_o        (level_o),
        .state_o        (state_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; valid_i = 1'b1; gate_i = 1'b0; sample_i = 24'sh400000;
        attack_step_i = 16'h4000; decay_step_i = 16'h1000;
        sustain_lvl_i = 16'h8000; release_step_i = 16'h3000;
        step(); step();
        tests++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_o, S_IDLE); end
        tests++; if (level_o !== 16'h0) begin errors++; $display("FAIL reset_level got %h exp 0000", level_o); end
        tests++; if (sample_o !== 24'h0) begin errors++; $display("FAIL reset_sample got %h exp 000000", sample_o); end
        tests++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        tests++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        reset_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            tests++;
            if (state_o !== S_IDLE || level_o !== 16'h0 || sample_o !== 24'h0) begin
                errors++;
                $display("FAIL idle_hold cyc %0d got st=%0d lvl=%h smp=%h exp 0/0000/000000", i, state_o, level_o, sample_o);
            end
        end
    endtask

    task automatic test_attack();
        logic [15:0] lvl_exp [4];
        logic [23:0] smp_exp [4];
        lvl_exp = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        smp_exp = '{24'h000000, 24'h100000, 24'h200000, 24'h300000};
        gate_i = 1'b1;
        step();
        tests++; if (state_o !== S_ATTACK || level_o !== 16'h0) begin errors++; $display("FAIL attack_entry got st=%0d lvl=%h exp 1/0000", state_o, level_o); end
        tests++; if (busy_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL attack_busy got busy=%b valid=%b exp 1/1", busy_o, valid_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (level_o !== lvl_exp[i] || sample_o !== smp_exp[i]) begin
                errors++;
                $display("FAIL attack_ramp %0d got lvl=%h smp=%h exp %h/%h", i, level_o, sample_o, lvl_exp[i], smp_exp[i]);
            end
        end
        tests++; if (state_o !== S_DECAY) begin errors++; $display("FAIL attack_peak_state got %0d exp %0d", state_o, S_DECAY); end
    endtask

    task automatic test_decay();
        step();
        tests++; if (level_o !== 16'hEFFF || sample_o !== 24'h3FFFC0) begin errors++; $display("FAIL decay_first got lvl=%h smp=%h exp EFFF/3fffc0", level_o, sample_o); end
        for (int i = 1; i < 7; i++) begin
            step();
            tests++;
            if (level_o !== 16'(16'hEFFF - i * 16'h1000) || state_o !== S_DECAY) begin
                errors++;
                $display("FAIL decay_step %0d got lvl=%h st=%0d exp %h/2", i, level_o, state_o, 16'(16'hEFFF - i * 16'h1000));
            end
        end
        step();
        tests++; if (level_o !== 16'h8000 || state_o !== S_SUSTAIN) begin errors++; $display("FAIL decay_to_sustain got lvl=%h st=%0d exp 8000/3", level_o, state_o); end
        sample_i = -24'sh400000;
        step();
        tests++; if (sample_o !== 24'hE00000) begin errors++; $display("FAIL sustain_neg_sample got %h exp e00000", sample_o); end
        sustain_lvl_i = 16'h6000;
        step();
        tests++; if (level_o !== 16'h6000 || state_o !== S_SUSTAIN) begin errors++; $display("FAIL sustain_track got lvl=%h st=%0d exp 6000/3", level_o, state_o); end
        sustain_lvl_i = 16'h8000;
        step();
        tests++; if (level_o !== 16'h8000) begin errors++; $display("FAIL sustain_track_back got %h exp 8000", level_o); end
    endtask

    task automatic test_release();
        logic [15:0] lvl_exp [3];
        lvl_exp = '{16'h5000, 16'h2000, 16'h0000};
        sample_i = 24'sh400000;
        gate_i = 1'b0;
        step();
        tests++; if (state_o !== S_RELEASE || level_o !== 16'h8000) begin errors++; $display("FAIL release_entry got st=%0d lvl=%h exp 4/8000", state_o, level_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (level_o !== lvl_exp[i]) begin errors++; $display("FAIL release_ramp %0d got %h exp %h", i, level_o, lvl_exp[i]); end
        end
        tests++; if (state_o !== S_IDLE || busy_o !== 1'b0) begin errors++; $display("FAIL release_idle got st=%0d busy=%b exp 0/0", state_o, busy_o); end
    endtask

    task automatic test_retrigger();
        attack_step_i = 16'h5000;
        gate_i = 1'b1;
        step(); step();
        tests++; if (level_o !== 16'h5000 || state_o !== S_ATTACK) begin errors++; $display("FAIL retrig_setup got lvl=%h st=%0d exp 5000/1", level_o, state_o); end
        gate_i = 1'b0;
        step();
        tests++; if (state_o !== S_RELEASE || level_o !== 16'h5000) begin errors++; $display("FAIL retrig_fall got st=%0d lvl=%h exp 4/5000", state_o, level_o); end
        gate_i = 1'b1;
        attack_step_i = 16'h4000;
        step();
        tests++; if (state_o !== S_ATTACK || level_o !== 16'h5000) begin errors++; $display("FAIL retrig_rise got st=%0d lvl=%h exp 1/5000", state_o, level_o); end
        step();
        tests++; if (level_o !== 16'h9000) begin errors++; $display("FAIL retrig_ramp1 got %h exp 9000", level_o); end
        step();
        tests++; if (level_o !== 16'hD000) begin errors++; $display("FAIL retrig_ramp2 got %h exp d000", level_o); end
        step();
        tests++; if (level_o !== 16'hFFFF || state_o !== S_DECAY) begin errors++; $display("FAIL attack_saturate got lvl=%h st=%0d exp ffff/2", level_o, state_o); end
    endtask

    task automatic test_zero_step();
        gate_i = 1'b0;
        reset_i = 1'b1; step(); reset_i = 1'b0;
        attack_step_i = 16'h0000; release_step_i = 16'h0000;
        gate_i = 1'b1;
        step(); step(); step();
        tests++; if (state_o !== S_ATTACK || level_o !== 16'h0) begin errors++; $display("FAIL zero_attack_stall got st=%0d lvl=%h exp 1/0000", state_o, level_o); end
        attack_step_i = 16'hFFFF; decay_step_i = 16'h0000; sustain_lvl_i = 16'hFFFF;
        step();
        tests++; if (state_o !== S_DECAY || level_o !== 16'hFFFF) begin errors++; $display("FAIL max_step_peak got st=%0d lvl=%h exp 2/ffff", state_o, level_o); end
        step();
        tests++; if (state_o !== S_SUSTAIN || level_o !== 16'hFFFF) begin errors++; $display("FAIL sustain_clamp_entry got st=%0d lvl=%h exp 3/ffff", state_o, level_o); end
        sustain_lvl_i = 16'h0000;
        step();
        gate_i = 1'b0;
        step(); step();
        tests++; if (state_o !== S_IDLE || level_o !== 16'h0) begin errors++; $display("FAIL zero_release_idle got st=%0d lvl=%h exp 0/0000", state_o, level_o); end
        decay_step_i = 16'h1000; sustain_lvl_i = 16'h8000; release_step_i = 16'h3000;
    endtask

    task automatic test_valid_hold();
        reset_i = 1'b1; step(); reset_i = 1'b0;
        attack_step_i = 16'h1000;
        sample_i = 24'sh400000;
        gate_i = 1'b1;
        step(); step(); step();
        tests++; if (level_o !== 16'h2000 || sample_o !== 24'h040000) begin errors++; $display("FAIL hold_setup got lvl=%h smp=%h exp 2000/040000", level_o, sample_o); end
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            gate_i = ~gate_i;
            sample_i = 24'sh123456 + 24'(i);
            step();
            tests++;
            if (level_o !== 16'h2000 || state_o !== S_ATTACK || sample_o !== 24'h040000 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen %0d got lvl=%h st=%0d smp=%h vld=%b exp 2000/1/040000/0", i, level_o, state_o, sample_o, valid_o);
            end
        end
        gate_i = 1'b1; valid_i = 1'b1; sample_i = 24'sh400000;
        step();
        tests++; if (level_o !== 16'h3000 || sample_o !== 24'h080000 || valid_o !== 1'b1) begin errors++; $display("FAIL hold_resume got lvl=%h smp=%h vld=%b exp 3000/080000/1", level_o, sample_o, valid_o); end
    endtask

    task automatic test_async_reset();
        attack_step_i = 16'hFFFF;
        step();
        step();
        tests++; if (state_o !== S_DECAY || level_o !== 16'hEFFF) begin errors++; $display("FAIL arst_setup got st=%0d lvl=%h exp 2/efff", state_o, level_o); end
        #1 reset_i = 1'b1;
        #1;
        tests++;
        if (state_o !== S_IDLE || level_o !== 16'h0 || sample_o !== 24'h0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_midnote got st=%0d lvl=%h smp=%h vld=%b busy=%b exp all 0", state_o, level_o, sample_o, valid_o, busy_o);
        end
        step();
        reset_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_retrigger();
        test_zero_step();
        test_valid_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
